// File: rtl/demux8_slot_pkg.sv
// Shared N-way slot constants and the slot state encoding, reused by selectors and distributors.
package demux8_slot_pkg;

    localparam int NUM_SLOTS = 8;
    localparam int SEL_W     = 3;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    function automatic logic [NUM_SLOTS-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
        logic [NUM_SLOTS-1:0] hot;
        hot      = '0;
        hot[sel] = 1'b1;
        return hot;
    endfunction

endpackage

// File: rtl/demux8_slot_slot.sv
// One-entry output slot: loaded word is visible after one edge; can refill on the same cycle it drains,
// so a consumer holding ready high sees no bubbles. Data is frozen while FULL and not drained.
module demux_slot
    import demux8_slot_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             drain_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             can_accept_o
);

    slot_state_e      state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    // A load wins over a drain: the slot stays FULL with the new word.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (load_i) begin
            state_d = SLOT_FULL;
            data_d  = data_i;
        end else if (state_q == SLOT_FULL && drain_i) begin
            state_d = SLOT_EMPTY;
        end
    end

    assign valid_o      = (state_q == SLOT_FULL);
    assign data_o       = data_q;
    assign can_accept_o = (state_q == SLOT_EMPTY) || drain_i;

endmodule

// File: rtl/demux8_slot.sv
// Registered 1-to-8 word distributor (unicast or broadcast); one edge from accept to out_valid.
// in_ready is combinational from slot state and out_ready only; a broadcast waits for all eight slots.
module demux8_slot
    import demux8_slot_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic                     in_bcast,
    output logic [NUM_SLOTS-1:0]     out_valid,
    input  logic [NUM_SLOTS-1:0]     out_ready,
    output logic [NUM_SLOTS*WIDTH-1:0] out_data,
    output logic                     busy
);

    logic [NUM_SLOTS-1:0] can_accept;
    logic [NUM_SLOTS-1:0] load;
    logic [NUM_SLOTS-1:0] dest;
    logic                 fire;

    always_comb begin
        dest     = in_bcast ? {NUM_SLOTS{1'b1}} : sel_onehot(in_sel);
        in_ready = in_bcast ? (&can_accept) : can_accept[in_sel];
        fire     = in_valid && in_ready;
        load     = {NUM_SLOTS{fire}} & dest;
        busy     = |out_valid;
    end

    for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_slot
        demux_slot #(.WIDTH(WIDTH)) u_slot (
            .clk          (clk),
            .rst          (rst),
            .load_i       (load[k]),
            .data_i       (in_data),
            .drain_i      (out_ready[k]),
            .valid_o      (out_valid[k]),
            .data_o       (out_data[WIDTH*k +: WIDTH]),
            .can_accept_o (can_accept[k])
        );
    end

endmodule

// File: doc/demux8_slot.md
# demux8_slot

Registered 1-to-8 result distributor, the inverse of the ALU's 8-way result selector. It accepts one WIDTH-bit word per cycle over a valid/ready handshake, along with a 3-bit destination index or a broadcast flag. It steers the word into one of eight single-entry output slots, or into all eight at once. The block sits between the ALU result path and up to eight downstream consumers, for example writeback ports or forwarding buffers, each of which drains its slot independently.

## Interface
Parameters:
- WIDTH, 32, data word width.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  producer offers a word this cycle.
- in_ready  out  1  block accepts the offered word this cycle.
- in_data  in  WIDTH  word to distribute.
- in_sel  in  3  destination slot index 0..7; ignored when in_bcast=1.
- in_bcast  in  1  write the word to all eight slots.
- out_valid  out  8  bit k: slot k holds a word.
- out_ready  in  8  bit k: consumer k takes slot k's word this cycle.
- out_data  out  8*WIDTH  slot k word on bits [WIDTH*k+WIDTH-1 : WIDTH*k].
- busy  out  1  OR of out_valid.

## Operation
- Each slot k has a state of EMPTY or FULL and one data register.
- Slot k can accept this cycle when it is EMPTY, or when it is FULL and out_ready[k]=1 (drain and refill in the same cycle).
- Unicast (in_bcast=0):
  - in_ready = can-accept(in_sel).
  - An accepted word is written to slot in_sel.
  - in_ready is purely combinational from slot state and out_ready. It must not depend on in_valid.
- Broadcast (in_bcast=1):
  - in_ready = AND of can-accept over all eight slots.
  - On acceptance, all eight slots load in_data and become FULL.
  - There is no partial broadcast.
- Drain: out_valid[k]=1 and out_ready[k]=1 moves slot k from FULL to EMPTY, unless the same cycle refills it (it stays FULL with the new data).
- out_valid[k] and out_data slice k come directly from slot registers; there is no combinational path from in_* to out_*.
- While out_valid[k]=1 and out_ready[k]=0, out_data slice k must remain stable.
- Slots are independent. A stalled consumer blocks only unicasts to its own slot and all broadcasts.

## Timing
- Reset values (asserted asynchronously):
  - All slots EMPTY; out_valid=8'h00; busy=0.
  - out_data all zero.
  - in_ready reflects EMPTY slots, so it reads 1 during and after reset.
- Latency: a word accepted at edge N appears on out_valid/out_data after edge N. Throughput is one word per cycle per slot when out_ready is held high.
- Simultaneous drain and fill of the same slot: the slot stays FULL with the new word, and the consumer sees back-to-back words with no bubble.
- Reset mid-operation: all held words are discarded immediately. No handshake is completed on a cycle in which rst is high.
- in_sel is don't-care when in_valid=0. in_sel and in_bcast must be held stable by the producer while in_valid=1 and in_ready=0.

## Structure
- Shared include/package holds:
  - NUM_SLOTS=8;
  - SEL_W=3;
  - slot state encoding (EMPTY=1'b0, FULL=1'b1).
  
  The ALU selector and future N-way blocks reuse these.
- Sub-module demux_slot: one-entry buffer with inputs load, data, drain and outputs valid, data, can_accept. Instantiated 8 times.
- Top level holds only select decode, broadcast AND-reduction, in_ready mux and busy OR-reduction.

## Test plan
- Reset: assert rst mid-stream with slots 2 and 5 FULL, then release. Required: out_valid=00, busy=0, in_ready=1.
- Unicast: in_data=32'hDEADBEEF, in_sel=3, out_ready=00. Required: after 1 edge, out_valid=08 and slice 3=DEADBEEF. A second unicast to slot 3 sees in_ready=0; a unicast to slot 4 is accepted.
- Back-to-back: stream 0x1,0x2,0x3 to slot 7 with out_ready[7]=1. Required: consumer sees 0x1,0x2,0x3 on consecutive cycles, in_ready constantly 1.
- Broadcast blocked: slot 6 FULL with out_ready[6]=0, then broadcast 32'hA5A5A5A5. Required: in_ready=0 and no slot changes. Raise out_ready[6]: the broadcast is accepted that cycle, then out_valid=FF with all slices A5A5A5A5.
- Stall stability: slot 0 FULL with 0x1234 and out_ready[0]=0 for 5 cycles while other slots stream. Required: slice 0 holds 0x1234 and out_valid[0] stays 1 throughout.
- Random: random in_sel, in_bcast and out_ready over 10k cycles against a per-slot scoreboard. Required: no loss, duplication or reordering per slot, and busy equals OR of out_valid every cycle.
